// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU: opcode encodings for the
// arithmetic and logic groups and the bit positions inside the 4-bit flag
// vector {N,Z,C,V}.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Arithmetic group, selected by selector2 when operacion = 0.
  typedef enum logic [2:0] {
    ARIT_ADD  = 3'b000,
    ARIT_SUB  = 3'b001,
    ARIT_MUL  = 3'b010,
    ARIT_SHL  = 3'b011,
    ARIT_SHR  = 3'b100,
    ARIT_SRA  = 3'b101,
    ARIT_RES6 = 3'b110,
    ARIT_RES7 = 3'b111
  } op_arit_e;

  // Logic group, selected by selector1 when operacion = 1.
  typedef enum logic [2:0] {
    LOG_AND    = 3'b000,
    LOG_OR     = 3'b001,
    LOG_XOR    = 3'b010,
    LOG_NAND   = 3'b011,
    LOG_NOR    = 3'b100,
    LOG_XNOR   = 3'b101,
    LOG_NOT_A  = 3'b110,
    LOG_PASS_B = 3'b111
  } op_log_e;

  localparam int FLAGS_W = 4;
  localparam int FLAG_N  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

endpackage

// File: rtl/alu_nucleo.sv
// -----------------------------------------------------------------------------
// alu_nucleo
// Purely combinational ALU core: result and {N,Z,C,V} flags from the effective
// operand a, operand b and the opcode fields.
// Ports:
//   i_a, i_b      N-bit operands (i_a is already accumulator-or-A)
//   i_operacion   1 = logic group (i_selector1), 0 = arithmetic (i_selector2)
//   i_selector1   logic opcode
//   i_selector2   arithmetic opcode
//   o_result      N-bit result (add/sub/mul modulo 2^N)
//   o_flags       {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_nucleo
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]       i_a,
  input  logic [N-1:0]       i_b,
  input  logic               i_operacion,
  input  logic [2:0]         i_selector1,
  input  logic [2:0]         i_selector2,
  output logic [N-1:0]       o_result,
  output logic [FLAGS_W-1:0] o_flags
);

  localparam int SW = $clog2(N);

  logic [N:0]     w_sum;
  logic [N-1:0]   w_diff;
  logic [2*N-1:0] w_prod;
  logic [SW-1:0]  w_shamt;
  logic           w_c;
  logic           w_v;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = i_a - i_b;
  assign w_prod  = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
  // Only the low log2(N) bits of B form the shift amount.
  assign w_shamt = i_b[SW-1:0];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    o_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    if (i_operacion) begin
      case (op_log_e'(i_selector1))
        LOG_AND:    o_result = i_a & i_b;
        LOG_OR:     o_result = i_a | i_b;
        LOG_XOR:    o_result = i_a ^ i_b;
        LOG_NAND:   o_result = ~(i_a & i_b);
        LOG_NOR:    o_result = ~(i_a | i_b);
        LOG_XNOR:   o_result = ~(i_a ^ i_b);
        LOG_NOT_A:  o_result = ~i_a;
        LOG_PASS_B: o_result = i_b;
        default:    o_result = '0;
      endcase
    end else begin
      case (op_arit_e'(i_selector2))
        ARIT_ADD: begin
          o_result = w_sum[N-1:0];
          w_c      = w_sum[N];
          // Overflow: same-sign operands producing a different-sign sum.
          w_v      = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
        end
        ARIT_SUB: begin
          o_result = w_diff;
          // Carry means "no borrow".
          w_c      = (i_a >= i_b);
          w_v      = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
        end
        ARIT_MUL: begin
          o_result = w_prod[N-1:0];
          w_c      = |w_prod[2*N-1:N];
        end
        ARIT_SHL: o_result = i_a << w_shamt;
        ARIT_SHR: o_result = i_a >> w_shamt;
        ARIT_SRA: o_result = $signed(i_a) >>> w_shamt;
        default:  o_result = '0;
      endcase
    end
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = o_result[N-1];
    o_flags[FLAG_Z] = (o_result == '0);
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/alu_registrada.sv
// -----------------------------------------------------------------------------
// alu_registrada
// Two-stage pipelined ALU with valid/ready on both sides and an internal
// accumulator that can replace operand A. Stage 1 captures the operands and
// opcode; stage 2 computes and registers result + flags.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake
//   A, B                   N-bit operands
//   operacion              1 = logic group, 0 = arithmetic group
//   selector1, selector2   logic / arithmetic opcodes
//   usar_acc               use the accumulator instead of A
//   limpiar_acc            clear the accumulator at the next edge
//   out_valid / out_ready  output handshake
//   out, flags             registered result and {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu_registrada
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       A,
  input  logic [N-1:0]       B,
  input  logic               operacion,
  input  logic [2:0]         selector1,
  input  logic [2:0]         selector2,
  input  logic               usar_acc,
  input  logic               limpiar_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out,
  output logic [FLAGS_W-1:0] flags
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         operacion;
    logic [2:0]   sel1;
    logic [2:0]   sel2;
    logic         usar_acc;
  } s1_t;

  logic               r_s1_valid;
  s1_t                r_s1;
  logic               r_out_valid;
  logic [N-1:0]       r_out;
  logic [FLAGS_W-1:0] r_flags;
  logic [N-1:0]       r_acc;

  logic               w_s2_adv;
  logic               w_in_fire;
  logic [N-1:0]       w_a;
  logic [N-1:0]       w_result;
  logic [FLAGS_W-1:0] w_flags;

  // Stage 1 moves on when the output slot is empty or being drained this
  // cycle; the input side then refills stage 1 in the same cycle.
  assign w_s2_adv  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign w_in_fire = in_valid && in_ready;

  // The accumulator is read in the compute cycle, so an op right behind a
  // usar_acc op already sees its freshly written result.
  assign w_a = r_s1.usar_acc ? r_acc : r_s1.a;

  alu_nucleo #(.N(N)) u_nucleo (
    .i_a         (w_a),
    .i_b         (r_s1.b),
    .i_operacion (r_s1.operacion),
    .i_selector1 (r_s1.sel1),
    .i_selector2 (r_s1.sel2),
    .o_result    (w_result),
    .o_flags     (w_flags)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
      r_acc       <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end

      if (w_s2_adv) begin
        r_out_valid <= 1'b1;
        r_out       <= w_result;
        r_flags     <= w_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Clear wins over the result write-back; the op computing this cycle
      // has already used the pre-clear value.
      if (limpiar_acc) begin
        r_acc <= '0;
      end else if (w_s2_adv) begin
        r_acc <= w_result;
      end
    end
  end

  // NOTE: the stage-1 payload has no reset; it is only ever consumed while
  // r_s1_valid is set, and r_s1_valid itself is reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1.a         <= A;
      r_s1.b         <= B;
      r_s1.operacion <= operacion;
      r_s1.sel1      <= selector1;
      r_s1.sel2      <= selector2;
      r_s1.usar_acc  <= usar_acc;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign flags     = r_flags;

endmodule
